instruction_encoder: RTL
========================

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  command present; in_ready  output  1  block accepts command.
REQ-005 fmt  input  2  00=R-type, 01=load (I), 10=store (S), 11=branch (SB).
REQ-006 rd, rs1, rs2  input  5 each  register fields; funct3  input  3; funct7  input  7 (R-type only).
REQ-007 imm  input  13  two's-complement immediate.
REQ-008 load, base_addr  input  1, 8  load pulse and start word address.
REQ-009 wr_en  output  1  write request; wr_addr  output  8  word address; wr_data  output  32  encoded instruction; mem_ready  input  1  memory accepts write.
REQ-010 err  output  1  one-cycle pulse on rejected command; full  output  1  sticky end-of-memory flag; count  output  9  words written.

Function
REQ-011 A command SHALL transfer on a rising edge when in_valid=1 and in_ready=1.
REQ-012 Encoding rules (opcode fixed by fmt):
- R: {funct7, rs2, rs1, funct3, rd, 0110011}
- load: {imm[11:0], rs1, funct3, rd, 0000011}
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011}
- SB: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011}
REQ-013 Fields not used by a format SHALL be ignored.
REQ-014 Latency: an accepted valid command SHALL appear on wr_en/wr_data on the next cycle, registered.
REQ-015 States: IDLE (no pending word), PEND (wr_en=1), FULL.
REQ-016 IDLE->PEND on accept of a valid command.
REQ-017 PEND->IDLE when mem_ready=1 and no new accept that cycle.
REQ-018 PEND->PEND when mem_ready=1 with a simultaneous accept, or when mem_ready=0.
REQ-019 PEND->FULL when mem_ready=1 while wr_addr=255.
REQ-020 in_ready SHALL equal (state=IDLE or (state=PEND and mem_ready=1 and wr_addr!=255)) and load=0.
REQ-021 wr_addr, wr_data and wr_en SHALL hold stable while wr_en=1 and mem_ready=0.
REQ-022 On each completed write (wr_en=1, mem_ready=1), wr_addr SHALL increment by 1 and count SHALL increment by 1.
REQ-023 count SHALL saturate at 256.
REQ-024 The write at address 255 SHALL set full=1 and enter FULL; wr_addr SHALL NOT wrap.
REQ-025 In FULL: in_ready=0, wr_en=0.
REQ-026 Rejection: SB with imm[0]=1, or load/S with imm[12]!=imm[11] (out of 12-bit range).
REQ-027 A rejected command SHALL be consumed, SHALL NOT be written, and SHALL pulse err for one cycle; a rejection in IDLE SHALL stay in IDLE.
REQ-028 load=1 in IDLE or FULL: wr_addr<=base_addr, count<=0, full<=0, next state IDLE.
REQ-029 load=1 in PEND SHALL be ignored.

Reset
REQ-030 While reset_n=0: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, count=0, full=0, err=0, in_ready=0.
REQ-031 An asserted reset during PEND SHALL discard the pending word without writing it.
REQ-032 in_ready SHALL rise on the first clock edge after reset_n deasserts.

Verification
REQ-033 R: fmt=00, funct7=0, rs2=2, rs1=1, funct3=0, rd=3, mem_ready=1 -> next cycle wr_en=1, wr_addr=0, wr_data=0x002081B3; count=1.
REQ-034 Load then store back-to-back, mem_ready=1:
- lw: rd=5, rs1=2, funct3=2, imm=8 -> 0x00812283 at address 0.
- sw: rs2=5, rs1=2, funct3=2, imm=12 -> 0x00512623 at address 1.
- No bubble between the two writes.
REQ-035 SB: rs1=1, rs2=2, funct3=0, imm=-4 (0x1FFC) -> 0xFE208EE3.
REQ-036 SB with imm=3 -> err pulses once, wr_en stays 0, count unchanged.
REQ-037 Backpressure: hold mem_ready=0 for 3 cycles with wr_en=1 -> wr_data/wr_addr stable, in_ready=0.
REQ-038 Fill and reload:
- load with base_addr=254, then 3 commands -> writes at 254 and 255, then full=1 and the third command stalls (in_ready=0).
- load with base_addr=0 -> full=0, third command written at address 0.

Source files
------------

// File: rtl/instruction_encoder_if.sv
// Command-in / memory-write-out bus of the instruction encoder.
// The master side drives commands and the memory handshake; the slave side is the encoder.
interface instruction_encoder_if;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned IMM_W   = 13;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned COUNT_W = 9;

  logic               in_valid;
  logic               in_ready;
  logic [1:0]         fmt;
  logic [REG_W-1:0]   rd;
  logic [REG_W-1:0]   rs1;
  logic [REG_W-1:0]   rs2;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic [IMM_W-1:0]   imm;
  logic               load;
  logic [ADDR_W-1:0]  base_addr;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic               mem_ready;
  logic               err;
  logic               full;
  logic [COUNT_W-1:0] count;

  modport master (
    output in_valid, fmt, rd, rs1, rs2, funct3, funct7, imm, load, base_addr, mem_ready,
    input  in_ready, wr_en, wr_addr, wr_data, err, full, count
  );

  modport slave (
    input  in_valid, fmt, rd, rs1, rs2, funct3, funct7, imm, load, base_addr, mem_ready,
    output in_ready, wr_en, wr_addr, wr_data, err, full, count
  );
endinterface

// File: rtl/instruction_encoder.sv
// Encodes R/I/S/SB commands into 32-bit RISC-V words and streams them to sequential
// memory addresses, with backpressure, rejection of bad immediates and an end-of-memory stop.
module instruction_encoder (
  input logic                  clk,
  input logic                  reset_n,
  instruction_encoder_if.slave bus
);
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned COUNT_W = 9;
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(255);
  localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(256);

  typedef enum logic [1:0] {IDLE, PEND, FULL} state_t;

  state_t              state, state_nxt;
  logic                live;
  logic [ADDR_W-1:0]   addr_q, addr_nxt;
  logic [DATA_W-1:0]   data_q, data_nxt;
  logic [COUNT_W-1:0]  count_q, count_nxt;
  logic                full_q, full_nxt;
  logic                err_q, err_nxt;
  logic [DATA_W-1:0]   enc;
  logic                reject;
  logic                accept;
  logic                last_addr;

  // Format-specific bit packing; unused fields simply do not appear in the word.
  always_comb begin
    enc    = '0;
    reject = 1'b0;
    case (bus.fmt)
      2'b00: enc = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, 7'b0110011};
      2'b01: begin
        enc    = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, 7'b0000011};
        reject = bus.imm[12] ^ bus.imm[11];
      end
      2'b10: begin
        enc    = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], 7'b0100011};
        reject = bus.imm[12] ^ bus.imm[11];
      end
      2'b11: begin
        enc    = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                  bus.imm[4:1], bus.imm[11], 7'b1100011};
        reject = bus.imm[0];
      end
    endcase
  end

  // live keeps in_ready low until the first edge after reset release.
  assign last_addr    = (addr_q == LAST_ADDR);
  assign bus.in_ready = live && !bus.load &&
                        ((state == IDLE) || ((state == PEND) && bus.mem_ready && !last_addr));
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.wr_en   = (state == PEND);
  assign bus.wr_addr = addr_q;
  assign bus.wr_data = data_q;
  assign bus.count   = count_q;
  assign bus.full    = full_q;
  assign bus.err     = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      live    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      live    <= 1'b1;
      addr_q  <= addr_nxt;
      data_q  <= data_nxt;
      count_q <= count_nxt;
      full_q  <= full_nxt;
      err_q   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    data_nxt  = data_q;
    count_nxt = count_q;
    full_nxt  = full_q;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load) begin
          addr_nxt  = bus.base_addr;
          count_nxt = '0;
          full_nxt  = 1'b0;
        end else if (accept) begin
          if (reject) begin
            err_nxt = 1'b1;
          end else begin
            data_nxt  = enc;
            state_nxt = PEND;
          end
        end
      end
      PEND: begin
        if (bus.mem_ready) begin
          count_nxt = (count_q == COUNT_MAX) ? count_q : COUNT_W'(count_q + COUNT_W'(1));
          if (last_addr) begin
            // Address never wraps: the last word parks the block in FULL.
            full_nxt  = 1'b1;
            state_nxt = FULL;
          end else begin
            addr_nxt = ADDR_W'(addr_q + ADDR_W'(1));
            if (accept && !reject) begin
              data_nxt = enc;
            end else begin
              err_nxt   = accept;
              state_nxt = IDLE;
            end
          end
        end
      end
      FULL: begin
        if (bus.load) begin
          addr_nxt  = bus.base_addr;
          count_nxt = '0;
          full_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
